// File: rtl/host_frame_buffer_if.sv
// Bus bundle for host_frame_buffer: collider pixel stream in, host read port out.
// The master modport is the producer/host side; the slave modport is the frame buffer.
interface host_frame_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 3,
  parameter int ADDR_WIDTH = 6
);
  logic                         frame_start;
  logic                         pix_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] pix_data;
  logic                         wr_busy;
  logic                         host_lock;
  logic                         rd_req;
  logic [ADDR_WIDTH-1:0]        rd_addr;
  logic [NUM_CH*DATA_WIDTH-1:0] rd_data;
  logic                         rd_valid;
  logic                         rd_bank_valid;
  logic [15:0]                  frame_count;
  logic [7:0]                   drop_count;

  modport master (
    output frame_start, pix_valid, pix_data, host_lock, rd_req, rd_addr,
    input  wr_busy, rd_data, rd_valid, rd_bank_valid, frame_count, drop_count
  );

  modport slave (
    input  frame_start, pix_valid, pix_data, host_lock, rd_req, rd_addr,
    output wr_busy, rd_data, rd_valid, rd_bank_valid, frame_count, drop_count
  );
endinterface

// File: rtl/host_frame_buffer.sv
// Ping-pong frame capture: the collider fills one bank while the host reads the other.
// A complete frame is committed by a bank swap, or dropped/stalled while the host holds the lock.
module host_frame_buffer #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CH       = 3,
  parameter int DEPTH        = 64,
  parameter int ADDR_WIDTH   = 6,
  parameter bit DROP_ON_LOCK = 1'b1
) (
  input logic               clk,
  input logic               rst,
  host_frame_buffer_if.slave bus
);
  localparam int PW    = NUM_CH * DATA_WIDTH;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_FILL   = 2'd1,
    W_COMMIT = 2'd2
  } w_state_t;

  w_state_t              state_r;
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic                  wr_bank_r;
  logic                  wr_busy_r;
  logic                  rd_bank_valid_r;
  logic                  rd_valid_r;
  logic [PW-1:0]         rd_data_r;
  logic [15:0]           frame_count_r;
  logic [7:0]            drop_count_r;
  logic [PW-1:0]         bank0_r [DEPTH];
  logic [PW-1:0]         bank1_r [DEPTH];

  logic                  wr_en_s;
  logic [IDX_W-1:0]      wr_idx_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic                  rd_in_range_s;
  logic [PW-1:0]         rd_word_s;
  logic                  commit_s;
  logic                  drop_s;

  // Write strobe: a frame_start pixel always lands at index 0, even mid-frame.
  always_comb begin
    wr_en_s  = 1'b0;
    wr_idx_s = wr_ptr_r[IDX_W-1:0];
    if (state_r != W_COMMIT && bus.frame_start) begin
      wr_en_s  = bus.pix_valid;
      wr_idx_s = '0;
    end else if (state_r == W_FILL) begin
      wr_en_s = bus.pix_valid;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Commit/drop decisions and read-side lookup from the bank opposite the writer.
  always_comb begin
    commit_s      = 1'b0;
    drop_s        = 1'b0;
    rd_idx_s      = bus.rd_addr[IDX_W-1:0];
    rd_in_range_s = ({1'b0, bus.rd_addr} < DEPTH_LIM);
    if (state_r == W_COMMIT) begin
      commit_s = !bus.host_lock;
      drop_s   = bus.host_lock && DROP_ON_LOCK;
    end else begin
      commit_s = 1'b0;
      drop_s   = 1'b0;
    end
    if (wr_bank_r) begin
      rd_word_s = bank0_r[rd_idx_s];
    end else begin
      rd_word_s = bank1_r[rd_idx_s];
    end
  end

  // Pixel storage, deliberately left without reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      if (wr_bank_r) begin
        bank1_r[wr_idx_s] <= bus.pix_data;
      end else begin
        bank0_r[wr_idx_s] <= bus.pix_data;
      end
    end
  end

  // Write-side FSM with frame/drop counters and bank ownership.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= W_IDLE;
      wr_ptr_r        <= '0;
      wr_bank_r       <= 1'b0;
      wr_busy_r       <= 1'b0;
      rd_bank_valid_r <= 1'b0;
      frame_count_r   <= 16'd0;
      drop_count_r    <= 8'd0;
    end else begin
      case (state_r)
        W_IDLE, W_FILL: begin
          if (bus.frame_start) begin
            state_r  <= W_FILL;
            wr_ptr_r <= bus.pix_valid ? PTR_ONE : '0;
          end else if (state_r == W_FILL && bus.pix_valid) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (wr_ptr_r == LAST_PTR) begin
              state_r   <= W_COMMIT;
              wr_busy_r <= 1'b1;
            end
          end
        end
        W_COMMIT: begin
          if (commit_s) begin
            wr_bank_r       <= ~wr_bank_r;
            frame_count_r   <= frame_count_r + 16'd1;
            rd_bank_valid_r <= 1'b1;
            wr_ptr_r        <= '0;
            wr_busy_r       <= 1'b0;
            state_r         <= W_IDLE;
          end else if (drop_s) begin
            if (drop_count_r != 8'hFF) begin
              drop_count_r <= drop_count_r + 8'd1;
            end
            wr_ptr_r  <= '0;
            wr_busy_r <= 1'b0;
            state_r   <= W_IDLE;
          end
        end
        default: begin
          state_r   <= W_IDLE;
          wr_ptr_r  <= '0;
          wr_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Host read port: one registered result per request, data held between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      rd_valid_r <= bus.rd_req;
      if (bus.rd_req) begin
        rd_data_r <= (rd_in_range_s && rd_bank_valid_r) ? rd_word_s : '0;
      end
    end
  end

  assign bus.wr_busy       = wr_busy_r;
  assign bus.rd_data       = rd_data_r;
  assign bus.rd_valid      = rd_valid_r;
  assign bus.rd_bank_valid = rd_bank_valid_r;
  assign bus.frame_count   = frame_count_r;
  assign bus.drop_count    = drop_count_r;
endmodule

// File: tb/tb_host_frame_buffer.sv
// Directed bench for host_frame_buffer: one drop-on-lock instance and one stall-on-lock instance.
module tb_host_frame_buffer;
  localparam int DW = 16;
  localparam int NC = 3;
  localparam int DEPTH = 64;
  localparam int AW = 7;
  localparam int PW = DW * NC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  host_frame_buffer_if #(.DATA_WIDTH(DW), .NUM_CH(NC), .ADDR_WIDTH(AW)) bif ();
  host_frame_buffer_if #(.DATA_WIDTH(DW), .NUM_CH(NC), .ADDR_WIDTH(AW)) bif_s ();

  host_frame_buffer #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
                      .DROP_ON_LOCK(1'b1)) dut (.clk(clk), .rst(rst), .bus(bif));
  host_frame_buffer #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
                      .DROP_ON_LOCK(1'b0)) dut_s (.clk(clk), .rst(rst), .bus(bif_s));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic          exp_valid;
    logic [PW-1:0] exp_data;
  } rd_vec_t;
  rd_vec_t vecs [5];

  function automatic logic [PW-1:0] pix(input logic [15:0] base, input int i);
    logic [15:0] b;
    b = base + 16'(i);
    return {b + 16'd200, b + 16'd100, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic stream(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bif.frame_start = (i == 0);
      bif.pix_valid   = 1'b1;
      bif.pix_data    = pix(base, i);
      tick();
    end
    bif.frame_start = 1'b0;
    bif.pix_valid   = 1'b0;
  endtask

  task automatic read_frame(input logic [15:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      bif.rd_req  = 1'b1;
      bif.rd_addr = AW'(i);
      tick();
      check("rd_valid_frame", 64'(bif.rd_valid), 64'd1);
      check("rd_data_frame", 64'(bif.rd_data), 64'(pix(base, i)));
    end
    bif.rd_req = 1'b0;
  endtask

  initial begin
    {bif.frame_start, bif.pix_valid, bif.host_lock, bif.rd_req} = 4'b0000;
    bif.pix_data = '0;
    bif.rd_addr  = '0;
    {bif_s.frame_start, bif_s.pix_valid, bif_s.host_lock, bif_s.rd_req} = 4'b0000;
    bif_s.pix_data = '0;
    bif_s.rd_addr  = '0;

    vecs[0] = '{1'b1, 7'd62, 1'b1, pix(16'h0000, 62)};
    vecs[1] = '{1'b1, 7'd63, 1'b1, pix(16'h0000, 63)};
    vecs[2] = '{1'b1, 7'd64, 1'b1, 48'h0};
    vecs[3] = '{1'b1, 7'd0,  1'b1, pix(16'h0000, 0)};
    vecs[4] = '{1'b0, 7'd5,  1'b0, pix(16'h0000, 0)};

    // Reset state
    tick();
    tick();
    check("rst_rd_valid", 64'(bif.rd_valid), 64'd0);
    check("rst_rd_data", 64'(bif.rd_data), 64'd0);
    check("rst_bank_valid", 64'(bif.rd_bank_valid), 64'd0);
    check("rst_frame_count", 64'(bif.frame_count), 64'd0);
    check("rst_drop_count", 64'(bif.drop_count), 64'd0);
    check("rst_wr_busy", 64'(bif.wr_busy), 64'd0);
    rst = 1'b0;

    // Read before any commit returns zero
    bif.rd_req  = 1'b1;
    bif.rd_addr = 7'd5;
    tick();
    check("pre_commit_valid", 64'(bif.rd_valid), 64'd1);
    check("pre_commit_data", 64'(bif.rd_data), 64'd0);
    bif.rd_req = 1'b0;
    tick();
    check("rd_valid_pulse", 64'(bif.rd_valid), 64'd0);

    // T1: first frame
    stream(16'h0000, DEPTH);
    check("t1_busy", 64'(bif.wr_busy), 64'd1);
    tick();
    check("t1_frame_count", 64'(bif.frame_count), 64'd1);
    check("t1_bank_valid", 64'(bif.rd_bank_valid), 64'd1);
    check("t1_busy_clear", 64'(bif.wr_busy), 64'd0);
    read_frame(16'h0000);

    // T5: back-to-back reads across the out-of-range boundary
    foreach (vecs[v]) begin
      bif.rd_req  = vecs[v].req;
      bif.rd_addr = vecs[v].addr;
      tick();
      check("t5_valid", 64'(bif.rd_valid), 64'(vecs[v].exp_valid));
      check("t5_data", 64'(bif.rd_data), 64'(vecs[v].exp_data));
    end

    // T2: frame completing under lock is dropped
    bif.host_lock = 1'b1;
    stream(16'h0100, DEPTH);
    check("t2_busy", 64'(bif.wr_busy), 64'd1);
    tick();
    check("t2_drop_count", 64'(bif.drop_count), 64'd1);
    check("t2_frame_count", 64'(bif.frame_count), 64'd1);
    check("t2_busy_clear", 64'(bif.wr_busy), 64'd0);
    bif.rd_req  = 1'b1;
    bif.rd_addr = 7'd10;
    tick();
    check("t2_locked_read", 64'(bif.rd_data), 64'(pix(16'h0000, 10)));
    bif.rd_req    = 1'b0;
    bif.host_lock = 1'b0;
    stream(16'h0300, DEPTH);
    bif.rd_req  = 1'b1;
    bif.rd_addr = 7'd5;
    tick();
    check("t2_frame_count2", 64'(bif.frame_count), 64'd2);
    check("t2_read_at_swap", 64'(bif.rd_data), 64'(pix(16'h0000, 5)));
    tick();
    check("t2_read_after_swap", 64'(bif.rd_data), 64'(pix(16'h0300, 5)));
    bif.rd_req = 1'b0;

    // T3: stall-on-lock instance holds the commit while locked
    bif_s.host_lock = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bif_s.frame_start = (i == 0);
      bif_s.pix_valid   = 1'b1;
      bif_s.pix_data    = pix(16'h0700, i);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      bif_s.frame_start = 1'b1;
      bif_s.pix_valid   = 1'b1;
      bif_s.pix_data    = '1;
      tick();
      check("t3_busy_locked", 64'(bif_s.wr_busy), 64'd1);
    end
    check("t3_no_commit", 64'(bif_s.frame_count), 64'd0);
    bif_s.host_lock   = 1'b0;
    bif_s.frame_start = 1'b0;
    bif_s.pix_valid   = 1'b0;
    tick();
    check("t3_frame_count", 64'(bif_s.frame_count), 64'd1);
    check("t3_busy_clear", 64'(bif_s.wr_busy), 64'd0);
    check("t3_drop_count", 64'(bif_s.drop_count), 64'd0);
    bif_s.rd_req  = 1'b1;
    bif_s.rd_addr = 7'd0;
    tick();
    check("t3_read0", 64'(bif_s.rd_data), 64'(pix(16'h0700, 0)));
    bif_s.rd_addr = 7'd63;
    tick();
    check("t3_read63", 64'(bif_s.rd_data), 64'(pix(16'h0700, 63)));
    bif_s.rd_req = 1'b0;

    // T4: restarted frame, partial one never committed
    stream(16'h0400, 20);
    tick();
    tick();
    check("t4_no_partial", 64'(bif.frame_count), 64'd2);
    stream(16'h0500, DEPTH);
    tick();
    check("t4_frame_count", 64'(bif.frame_count), 64'd3);
    read_frame(16'h0500);

    // T6: async reset mid-frame with a read in flight
    stream(16'h0600, 30);
    bif.rd_req  = 1'b1;
    bif.rd_addr = 7'd3;
    tick();
    check("t6_pre_rst_valid", 64'(bif.rd_valid), 64'd1);
    check("t6_pre_rst_data", 64'(bif.rd_data), 64'(pix(16'h0500, 3)));
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(bif.rd_valid), 64'd0);
    check("t6_rst_data", 64'(bif.rd_data), 64'd0);
    check("t6_rst_frames", 64'(bif.frame_count), 64'd0);
    check("t6_rst_drops", 64'(bif.drop_count), 64'd0);
    check("t6_rst_bank_valid", 64'(bif.rd_bank_valid), 64'd0);
    bif.rd_req = 1'b0;
    tick();
    rst = 1'b0;
    bif.pix_valid = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    bif.pix_valid = 1'b0;
    tick();
    check("t6_idle_ignores_pixels", 64'(bif.frame_count), 64'd0);
    check("t6_idle_not_busy", 64'(bif.wr_busy), 64'd0);

    // Drop counter saturation
    bif.host_lock = 1'b1;
    for (int k = 0; k < 300; k++) begin
      stream(16'(k), DEPTH);
      tick();
    end
    check("t6_drop_sat", 64'(bif.drop_count), 64'd255);
    check("t6_no_frames", 64'(bif.frame_count), 64'd0);
    bif.rd_req  = 1'b1;
    bif.rd_addr = 7'd0;
    tick();
    check("t6_invalid_bank_valid", 64'(bif.rd_valid), 64'd1);
    check("t6_invalid_bank_data", 64'(bif.rd_data), 64'd0);
    bif.rd_req    = 1'b0;
    bif.host_lock = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
